// File: rtl/audio_pkg.sv
//------------------------------------------------------------------------------
// audio_pkg : shared sample width, clock-divider defaults and helpers
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package audio_pkg;

  localparam int SAMPLE_W        = 16;
  localparam int MCLK_HALF_DEF   = 2;
  localparam int BCLK_HALF_DEF   = 16;
  localparam int BITS_PER_CH_DEF = 32;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Counter width that stays legal when a divide ratio is 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/audio_clk_div.sv
//------------------------------------------------------------------------------
// audio_clk_div : MCLK/BCLK/LRCLK dividers with a frame_start strobe
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module audio_clk_div
  import audio_pkg::*;
#(
  parameter int MCLK_HALF   = MCLK_HALF_DEF,
  parameter int BCLK_HALF   = BCLK_HALF_DEF,
  parameter int BITS_PER_CH = BITS_PER_CH_DEF
) (
  input  logic CLK,
  input  logic RESET,
  output logic MCLK,
  output logic BCLK,
  output logic LRCLK,
  output logic frame_start
);

  localparam int MW = cnt_w(MCLK_HALF);
  localparam int BW = cnt_w(BCLK_HALF);
  localparam int LW = cnt_w(BITS_PER_CH);
  localparam logic [MW-1:0] MCLK_LAST = MW'(MCLK_HALF - 1);
  localparam logic [BW-1:0] BCLK_LAST = BW'(BCLK_HALF - 1);
  localparam logic [LW-1:0] BIT_LAST  = LW'(BITS_PER_CH - 1);

  logic [MW-1:0] mcnt_q;
  logic [BW-1:0] bcnt_q;
  logic [LW-1:0] bit_q;
  logic          mclk_q, bclk_q, lrclk_q;
  logic          bclk_fall, slot_end;

  // frame_start is combinational so the top acts on the same edge LRCLK rises.
  always_comb begin
    bclk_fall   = (bcnt_q == BCLK_LAST) && bclk_q;
    slot_end    = bclk_fall && (bit_q == BIT_LAST);
    frame_start = slot_end && !lrclk_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mcnt_q  <= '0;
      bcnt_q  <= '0;
      bit_q   <= '0;
      mclk_q  <= 1'b0;
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
    end else begin
      mcnt_q <= (mcnt_q == MCLK_LAST) ? '0 : mcnt_q + 1'b1;
      if (mcnt_q == MCLK_LAST) mclk_q <= ~mclk_q;
      bcnt_q <= (bcnt_q == BCLK_LAST) ? '0 : bcnt_q + 1'b1;
      if (bcnt_q == BCLK_LAST) bclk_q <= ~bclk_q;
      if (bclk_fall) bit_q <= slot_end ? '0 : bit_q + 1'b1;
      if (slot_end) lrclk_q <= ~lrclk_q;
    end
  end

  assign MCLK  = mclk_q;
  assign BCLK  = bclk_q;
  assign LRCLK = lrclk_q;

endmodule

`default_nettype wire

// File: rtl/i2s_frame_gen.sv
//------------------------------------------------------------------------------
// i2s_frame_gen : I2S codec clocks plus one-deep sample buffer per frame
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module i2s_frame_gen
  import audio_pkg::*;
#(
  parameter int MCLK_HALF   = MCLK_HALF_DEF,
  parameter int BCLK_HALF   = BCLK_HALF_DEF,
  parameter int BITS_PER_CH = BITS_PER_CH_DEF
) (
  input  logic          CLK,
  input  logic          RESET,
  input  sample_t       in_left,
  input  sample_t       in_right,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          MCLK,
  output logic          BCLK,
  output logic          LRCLK,
  output sample_t       out_left,
  output sample_t       out_right,
  output logic          sample_req,
  output logic          underrun,
  output logic [15:0]   underrun_count
);

  logic frame_start;

  audio_clk_div #(
    .MCLK_HALF  (MCLK_HALF),
    .BCLK_HALF  (BCLK_HALF),
    .BITS_PER_CH(BITS_PER_CH)
  ) u_clk_div (
    .CLK        (CLK),
    .RESET      (RESET),
    .MCLK       (MCLK),
    .BCLK       (BCLK),
    .LRCLK      (LRCLK),
    .frame_start(frame_start)
  );

  sample_t     pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  sample_t     out_l_q, out_l_d, out_r_q, out_r_d;
  logic        pend_full_q, pend_full_d;
  logic        sample_req_q, sample_req_d;
  logic        underrun_q, underrun_d;
  logic [15:0] underrun_count_q, underrun_count_d;
  logic        xfer;

  assign in_ready = !pend_full_q;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    pend_l_d         = pend_l_q;
    pend_r_d         = pend_r_q;
    out_l_d          = out_l_q;
    out_r_d          = out_r_q;
    pend_full_d      = pend_full_q;
    sample_req_d     = 1'b0;
    underrun_d       = 1'b0;
    underrun_count_d = underrun_count_q;
    if (frame_start) begin
      sample_req_d = 1'b1;
      if (pend_full_q) begin
        out_l_d     = pend_l_q;
        out_r_d     = pend_r_q;
        pend_full_d = 1'b0;
      end else if (xfer) begin
        out_l_d = in_left;
        out_r_d = in_right;
      end else begin
        underrun_d = 1'b1;
        if (underrun_count_q != 16'hFFFF) underrun_count_d = underrun_count_q + 16'd1;
      end
    end else if (xfer) begin
      pend_l_d    = in_left;
      pend_r_d    = in_right;
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend_l_q         <= '0;
      pend_r_q         <= '0;
      out_l_q          <= '0;
      out_r_q          <= '0;
      pend_full_q      <= 1'b0;
      sample_req_q     <= 1'b0;
      underrun_q       <= 1'b0;
      underrun_count_q <= '0;
    end else begin
      pend_l_q         <= pend_l_d;
      pend_r_q         <= pend_r_d;
      out_l_q          <= out_l_d;
      out_r_q          <= out_r_d;
      pend_full_q      <= pend_full_d;
      sample_req_q     <= sample_req_d;
      underrun_q       <= underrun_d;
      underrun_count_q <= underrun_count_d;
    end
  end

  assign out_left       = out_l_q;
  assign out_right      = out_r_q;
  assign sample_req     = sample_req_q;
  assign underrun       = underrun_q;
  assign underrun_count = underrun_count_q;

endmodule

`default_nettype wire

// File: doc/i2s_frame_gen.md
I2S_FRAME_GEN -- requirements
Module: i2s_frame_gen

Interface
REQ-001 SHALL have parameter MCLK_HALF, default 2, CLK cycles per MCLK half-period.
REQ-002 SHALL have parameter BCLK_HALF, default 16, CLK cycles per BCLK half-period.
REQ-003 SHALL have parameter BITS_PER_CH, default 32, BCLK periods per LRCLK half (one channel slot).
REQ-004 SHALL have port CLK, input, 1, system clock; the only clock.
REQ-005 SHALL have port RESET, input, 1, synchronous, active-high.
REQ-006 SHALL have port in_left, input, signed 16, left sample from the distortion DSP.
REQ-007 SHALL have port in_right, input, signed 16, right sample.
REQ-008 SHALL have port in_valid, input, 1, in_left/in_right valid.
REQ-009 SHALL have port in_ready, output, 1, pending buffer can accept.
REQ-010 SHALL have ports MCLK, BCLK, LRCLK, output, 1 each; codec clocks, all registered.
REQ-011 SHALL have ports out_left, out_right, output, signed 16; samples held for the serializer.
REQ-012 SHALL have port sample_req, output, 1, one-CLK pulse at each frame start.
REQ-013 SHALL have port underrun, output, 1, one-CLK pulse when a frame repeats old data.
REQ-014 SHALL have port underrun_count, output, 16, saturating underrun total.

Function
REQ-015 SHALL toggle MCLK every MCLK_HALF CLK cycles and BCLK every BCLK_HALF cycles from free-running counters.
REQ-016 SHALL toggle LRCLK on the same CLK edge as the BITS_PER_CH-th BCLK falling edge of each slot; LRCLK=1 is left, 0 is right.
REQ-017 SHALL define frame start as the CLK edge on which LRCLK goes 0->1.
REQ-018 SHALL assert in_ready = NOT pending_full; a transfer occurs when in_valid AND in_ready.
REQ-019 SHALL, at frame start with pending_full, load out_left/out_right from pending, clear pending_full, and pulse sample_req on that edge.
REQ-020 SHALL, at frame start with pending empty and a transfer on that cycle, bypass it into out_left/out_right; no underrun.
REQ-021 SHALL, at frame start with pending empty and no transfer, hold out_left/out_right, pulse underrun, and increment underrun_count, saturating at 65535.
REQ-022 SHALL capture a transfer into pending in non-frame-start cycles, setting pending_full.
REQ-023 SHALL keep out_left/out_right constant between frame starts.
REQ-024 SHALL keep in_ready=0 at a frame start with pending_full, so a new sample is never taken while pending is drained; it is accepted the next cycle.

Reset
REQ-025 SHALL, while RESET=1, force MCLK=BCLK=LRCLK=0, out_left=out_right=0, pending_full=0, sample_req=underrun=0, underrun_count=0, and all divider counters=0.
REQ-026 SHALL make the first LRCLK rise BCLK_HALF*2*BITS_PER_CH CLK cycles after RESET deasserts; a mid-frame reset restarts that timing.

Structure
REQ-027 SHALL take sample width (16) and the parameter defaults from shared package audio_pkg.
REQ-028 SHALL implement the MCLK/BCLK/LRCLK counters in sub-module audio_clk_div, emitting a frame_start strobe; buffering and handshake stay in i2s_frame_gen.

Verification (defaults; cycle N = Nth CLK edge after RESET falls)
REQ-029 SHALL check clocks: MCLK period 4, BCLK period 32, LRCLK rises at cycle 1024, falls at 2048, rises at 3072.
REQ-030 SHALL check: drive 0x1234/0xABCD with in_valid at cycle 10 -> in_ready=0 from cycle 11; at cycle 1024 out_left=0x1234, out_right=0xABCD, sample_req pulse; in_ready=1 at cycle 1025.
REQ-031 SHALL check underrun: no input after the first frame -> at cycle 3072 outputs unchanged, underrun pulse, underrun_count=1.
REQ-032 SHALL check bypass: pending empty, drive 0x7FFF/0x8000 valid only at cycle 3072 -> outputs update on that edge, underrun=0.
REQ-033 SHALL check saturation: force 65540 frames without input -> underrun_count stays 65535.
REQ-034 SHALL check reset: assert RESET at cycle 1500 with pending_full -> all outputs 0 next cycle; LRCLK next rises 1024 cycles after release.
